interrupt_sequencer: RTL

- Controller for the 6502 bus routing datapath. Runs the 7-cycle interrupt/reset entry sequence: two dummy cycles, three stack pushes (PCH, PCL, P), then two vector fetches.
- Drives the routing select lines (source enables, open-drain zero strobes) and the bus R/W while in control. The instruction decoder owns those lines whenever o_active is low.
- Handles RESET, NMI and IRQ with fixed priority, NMI edge latch, IRQ masking and RDY stalls.

---
 rtl/cpu6502_pkg.sv | 29 ++
 rtl/interrupt_sequencer_if.sv | 25 ++
 rtl/interrupt_sequencer_request_latch.sv | 35 +++
 rtl/interrupt_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared 6502 routing-control definitions: sequencer states, vector codes
// and the ADL zero-strobe masks used during vector fetches.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    RST_PEND, IDLE, DUMMY, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H
  } seq_state_e;

  localparam logic [1:0] VEC_NMI   = 2'd0;
  localparam logic [1:0] VEC_RESET = 2'd1;
  localparam logic [1:0] VEC_IRQ   = 2'd2;

  // Masks are {adl2, adl1, adl0}; a set bit pulls that ADL line to zero.
  localparam logic [2:0] ADL_LO_NMI   = 3'b101;  // FA
  localparam logic [2:0] ADL_LO_RESET = 3'b011;  // FC
  localparam logic [2:0] ADL_LO_IRQ   = 3'b001;  // FE
  localparam logic [2:0] ADL_HI_NMI   = 3'b100;  // FB
  localparam logic [2:0] ADL_HI_RESET = 3'b010;  // FD
  localparam logic [2:0] ADL_HI_IRQ   = 3'b000;  // FF

  function automatic logic [2:0] adl_mask(input logic [1:0] vec, input logic hi);
    case (vec)
      VEC_NMI:   adl_mask = hi ? ADL_HI_NMI   : ADL_LO_NMI;
      VEC_RESET: adl_mask = hi ? ADL_HI_RESET : ADL_LO_RESET;
      default:   adl_mask = hi ? ADL_HI_IRQ   : ADL_LO_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Routing-control bundle driven by the interrupt sequencer while it owns the
// 6502 datapath; the instruction decoder side reads it through the slave view.
interface interrupt_sequencer_if;
  logic       o_active;
  logic [1:0] o_vector;
  logic       o_pch_db, o_pcl_db, o_p_db;
  logic       o_s_adl;
  logic       o_0_adl0, o_0_adl1, o_0_adl2, o_0_adh0, o_0_adh1_7;
  logic       o_rw;
  logic       o_s_dec;
  logic       o_dl_pcl, o_dl_pch;
  logic       o_set_i;
  logic       o_done;

  modport master (
    output o_active, o_vector, o_pch_db, o_pcl_db, o_p_db, o_s_adl,
           o_0_adl0, o_0_adl1, o_0_adl2, o_0_adh0, o_0_adh1_7,
           o_rw, o_s_dec, o_dl_pcl, o_dl_pch, o_set_i, o_done
  );
  modport slave (
    input  o_active, o_vector, o_pch_db, o_pcl_db, o_p_db, o_s_adl,
           o_0_adl0, o_0_adl1, o_0_adl2, o_0_adh0, o_0_adh1_7,
           o_rw, o_s_dec, o_dl_pcl, o_dl_pch, o_set_i, o_done
  );
endinterface

// File: rtl/interrupt_sequencer_request_latch.sv
// NMI edge latch, IRQ masking and NMI-over-IRQ priority; RESET priority is
// handled by the sequencer's RST_PEND state.
module interrupt_request_latch
  import cpu6502_pkg::*;
#(
  parameter bit NMI_EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       p_i,
  input  logic       nmi_clr,
  output logic       pending,
  output logic [1:0] vec
);
  logic nmi_prev, nmi_lat, nmi_req, irq_req;

  // A fresh edge wins over a same-cycle clear so it is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nmi_prev <= 1'b1;
      nmi_lat  <= 1'b0;
    end else begin
      nmi_prev <= nmi_n;
      if (nmi_prev && !nmi_n) nmi_lat <= 1'b1;
      else if (nmi_clr)       nmi_lat <= 1'b0;
    end
  end

  assign nmi_req = NMI_EDGE ? nmi_lat : !nmi_n;
  assign irq_req = !irq_n && !p_i;
  assign pending = nmi_req || irq_req;
  assign vec     = nmi_req ? VEC_NMI : VEC_IRQ;
endmodule

// File: rtl/interrupt_sequencer.sv
// 7-cycle RESET/NMI/IRQ entry sequencer: dummy cycles, PCH/PCL/P pushes and
// vector fetch, driving the routing selects while o_active is high.
module interrupt_sequencer
  import cpu6502_pkg::*;
#(
  parameter int DUMMY_CYCLES = 2,
  parameter bit NMI_EDGE     = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_nmi_n,
  input  logic                   i_irq_n,
  input  logic                   i_p_i,
  input  logic                   i_sync,
  input  logic                   i_rdy,
  interrupt_sequencer_if.master  bus
);
  localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_CYCLES - 1);

  seq_state_e state, state_nx;
  logic [1:0] cnt, cnt_nx, vec_q, vec_nx, req_vec;
  logic       armed, req_pending, nmi_clr;

  assign nmi_clr = i_rdy && (state == VEC_L) && (vec_q == VEC_NMI);

  interrupt_request_latch #(.NMI_EDGE(NMI_EDGE)) u_req (
    .clk(i_clk), .reset_n(i_reset_n), .nmi_n(i_nmi_n), .irq_n(i_irq_n),
    .p_i(i_p_i), .nmi_clr(nmi_clr), .pending(req_pending), .vec(req_vec)
  );

  // armed holds outputs at their reset values through the release cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= RST_PEND;
      cnt   <= '0;
      vec_q <= VEC_RESET;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      vec_q <= vec_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    vec_nx   = vec_q;
    if (i_rdy) begin
      case (state)
        RST_PEND: begin state_nx = DUMMY; cnt_nx = '0; vec_nx = VEC_RESET; end
        IDLE: if (i_sync && req_pending) begin
          state_nx = DUMMY; cnt_nx = '0; vec_nx = req_vec;
        end
        DUMMY: begin
          if (cnt == DUMMY_LAST) state_nx = PUSH_H;
          else                   cnt_nx   = cnt + 2'd1;
        end
        PUSH_H:  state_nx = PUSH_L;
        PUSH_L:  state_nx = PUSH_P;
        PUSH_P:  state_nx = VEC_L;
        VEC_L:   state_nx = VEC_H;
        VEC_H:   state_nx = IDLE;
        default: state_nx = RST_PEND;
      endcase
    end
  end

  // End-of-cycle strobes are qualified by i_rdy; selects just hold.
  always_comb begin
    bus.o_active   = armed && (state != IDLE);
    bus.o_vector   = vec_q;
    bus.o_pch_db   = 1'b0;
    bus.o_pcl_db   = 1'b0;
    bus.o_p_db     = 1'b0;
    bus.o_s_adl    = 1'b0;
    bus.o_0_adl0   = 1'b0;
    bus.o_0_adl1   = 1'b0;
    bus.o_0_adl2   = 1'b0;
    bus.o_0_adh0   = 1'b0;
    bus.o_0_adh1_7 = 1'b0;
    bus.o_rw       = 1'b1;
    bus.o_s_dec    = 1'b0;
    bus.o_dl_pcl   = 1'b0;
    bus.o_dl_pch   = 1'b0;
    bus.o_set_i    = 1'b0;
    bus.o_done     = 1'b0;
    if (armed) begin
      case (state)
        PUSH_H, PUSH_L, PUSH_P: begin
          bus.o_s_adl    = 1'b1;
          bus.o_0_adh1_7 = 1'b1;
          bus.o_s_dec    = i_rdy;
          bus.o_rw       = (vec_q == VEC_RESET);
          bus.o_pch_db   = (state == PUSH_H);
          bus.o_pcl_db   = (state == PUSH_L);
          bus.o_p_db     = (state == PUSH_P);
        end
        VEC_L: begin
          {bus.o_0_adl2, bus.o_0_adl1, bus.o_0_adl0} = adl_mask(vec_q, 1'b0);
          bus.o_dl_pcl = i_rdy;
          bus.o_set_i  = i_rdy;
        end
        VEC_H: begin
          {bus.o_0_adl2, bus.o_0_adl1, bus.o_0_adl0} = adl_mask(vec_q, 1'b1);
          bus.o_dl_pch = i_rdy;
          bus.o_done   = i_rdy;
        end
        default: ;
      endcase
    end
  end
endmodule
